// File: rtl/proc_seq_ctrl.sv
// Frame sequencer for data_proc. It takes a (mode, frame count) command and
// drives the processor's mode/start controls one frame at a time. It counts
// output beats to detect the end of each frame, and holds start low for a
// fixed gap between frames. It reports completion, progress and error status.
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid and cmd_ready are both 1. cmd_ready is registered and is only
// high in IDLE. The host holds cmd_mode/cmd_frames stable while cmd_valid=1
// and cmd_ready=0. A beat is proc_valid_out & sink_ready in RUN. Beats in
// any other state are ignored.
module proc_seq_ctrl #(
  parameter int PIXELS_PER_FRAME = 1024,
  parameter int GAP_CYCLES       = 20,
  parameter int TIMEOUT_CYCLES   = 4096,
  parameter int CNT_W            = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [7:0]       cmd_frames,
  input  logic             abort,
  input  logic             sink_ready,
  output logic             proc_ready_in,
  input  logic             proc_valid_out,
  output logic [1:0]       proc_mode,
  output logic             proc_start,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [7:0]       frames_done,
  output logic [CNT_W-1:0] pix_cnt,
  output logic [2:0]       dbg_state
);

  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_next;

  logic [7:0]       frames_req;
  logic             cancel;     // no further frames: abort or timeout seen
  logic [WD_W-1:0]  wd_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic accept, beat, frame_end, last_frame, timeout, gap_last, more_frames;

  assign proc_ready_in = sink_ready;
  assign dbg_state     = state;

  assign accept      = (state == S_IDLE) && cmd_valid && cmd_ready;
  assign beat        = (state == S_RUN) && proc_valid_out && sink_ready;
  assign frame_end   = beat && (pix_cnt == CNT_W'(PIXELS_PER_FRAME - 1));
  assign last_frame  = ({1'b0, frames_done} + 9'd1) == {1'b0, frames_req};
  // A beat in the same cycle always beats the watchdog.
  assign timeout     = (state == S_RUN) && !beat &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign gap_last    = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign more_frames = (frames_done < frames_req);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_ARM;
      S_ARM: begin
        if (abort)                   state_next = S_GAP;
        else if (frames_req == 8'd0) state_next = S_DONE;
        else                         state_next = S_RUN;
      end
      S_RUN:  if (abort || frame_end || timeout) state_next = S_GAP;
      S_GAP: begin
        // An abort restarts the gap, so GAP only ends on a quiet cycle.
        if (!abort && gap_last)
          state_next = (more_frames && !cancel) ? S_RUN : S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered control outputs, derived from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      proc_start <= 1'b0;
      done       <= 1'b0;
      proc_mode  <= 2'b00;
    end else begin
      cmd_ready  <= (state_next == S_IDLE);
      busy       <= (state_next != S_IDLE);
      proc_start <= (state_next == S_RUN);
      done       <= (state_next == S_DONE);
      // Mode only changes when entering ARM, never while start is high.
      if (accept) proc_mode <= cmd_mode;
    end
  end

  // Command latch, beat/frame counters and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_req  <= 8'd0;
      cancel      <= 1'b0;
      status      <= ST_OK;
      frames_done <= 8'd0;
      pix_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            frames_req  <= cmd_frames;
            cancel      <= 1'b0;
            status      <= ST_OK;
            frames_done <= 8'd0;
            pix_cnt     <= '0;
          end
        end
        S_ARM, S_GAP: begin
          if (abort) begin
            status <= ST_ABORT;
            cancel <= 1'b1;
          end
        end
        S_RUN: begin
          if (beat) begin
            if (frame_end) begin
              frames_done <= frames_done + 8'd1;
              pix_cnt     <= '0;
            end else begin
              pix_cnt <= pix_cnt + CNT_W'(1);
            end
          end
          // Beat is counted first. An abort on the beat that finishes the
          // last frame leaves the command successful.
          if (abort) begin
            cancel <= 1'b1;
            status <= (frame_end && last_frame) ? ST_OK : ST_ABORT;
          end else if (timeout) begin
            cancel <= 1'b1;
            status <= ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  // Watchdog and gap timers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      if (state_next == S_RUN && state != S_RUN) wd_cnt <= '0;
      else if (state == S_RUN) wd_cnt <= beat ? '0 : wd_cnt + WD_W'(1);

      if (state_next == S_GAP && (state != S_GAP || abort)) gap_cnt <= '0;
      else if (state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// Bench for proc_seq_ctrl: a cycle-level reference model is built from the
// sequencing rules. A negedge compare process, a done/status scoreboard and
// directed literal expectations check the DUT against it.
`timescale 1ns/100ps
module tb_proc_seq_ctrl;

  localparam int PPF = 16;
  localparam int GAP = 4;
  localparam int TMO = 64;
  localparam int CW  = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_mode = 2'b00;
  logic [7:0]    cmd_frames = 8'd0;
  logic          abort = 1'b0;
  logic          sink_ready = 1'b0;
  logic          proc_ready_in;
  logic          proc_valid_out = 1'b0;
  logic [1:0]    proc_mode;
  logic          proc_start;
  logic          busy;
  logic          done;
  logic [1:0]    status;
  logic [7:0]    frames_done;
  logic [CW-1:0] pix_cnt;
  logic [2:0]    dbg_state;

  proc_seq_ctrl #(
    .PIXELS_PER_FRAME(PPF), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_frames(cmd_frames), .abort(abort),
    .sink_ready(sink_ready), .proc_ready_in(proc_ready_in),
    .proc_valid_out(proc_valid_out), .proc_mode(proc_mode),
    .proc_start(proc_start), .busy(busy), .done(done), .status(status),
    .frames_done(frames_done), .pix_cnt(pix_cnt), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus controls ----------------
  int valid_pct    = 100;  // percent of cycles with proc_valid_out
  int ready_sel    = 0;    // 0 always ready, 1 toggle, 2 random
  int abort_permil = 0;    // random abort rate
  bit abort_force  = 1'b0;

  // Per-cycle data-path driver, 2ns after the edge
  always @(posedge clk) begin
    #2;
    if (ready_sel == 0)      sink_ready = 1'b1;
    else if (ready_sel == 1) sink_ready = ~sink_ready;
    else                     sink_ready = 1'($urandom_range(1));
    proc_valid_out = ($urandom_range(99) < valid_pct);
    abort = abort_force || ($urandom_range(999) < abort_permil);
  end

  // ---------------- reference model ----------------
  typedef enum int {PH_IDLE, PH_ARM, PH_RUN, PH_GAP, PH_DONE} phase_t;
  phase_t     m_phase = PH_IDLE;
  bit         m_ready_ok = 1'b0;  // ready only after the first post-reset edge
  logic [1:0] m_mode = 2'b00;
  int         m_req = 0, m_fdone = 0, m_pix = 0, m_quiet = 0, m_gap_left = 0;
  int         m_status = 0;
  bit         m_stop = 1'b0;
  logic [1:0] exp_q[$];           // status expected on each done pulse

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = PH_IDLE; m_ready_ok = 1'b0; m_mode = 2'b00;
      m_req = 0; m_fdone = 0; m_pix = 0; m_quiet = 0; m_gap_left = 0;
      m_status = 0; m_stop = 1'b0;
      exp_q.delete();
    end else begin
      bit completed;
      completed = 1'b0;
      case (m_phase)
        PH_IDLE: if (cmd_valid && m_ready_ok) begin
          m_req = cmd_frames; m_mode = cmd_mode; m_status = 0;
          m_fdone = 0; m_pix = 0; m_stop = 1'b0; m_phase = PH_ARM;
        end
        PH_ARM: begin
          if (abort) begin
            m_status = 2; m_stop = 1'b1; m_phase = PH_GAP; m_gap_left = GAP;
          end else if (m_req == 0) m_phase = PH_DONE;
          else begin m_phase = PH_RUN; m_quiet = 0; end
        end
        PH_RUN: begin
          if (proc_valid_out && sink_ready) begin
            m_pix++; m_quiet = 0;
            if (m_pix == PPF) begin m_fdone++; m_pix = 0; completed = 1'b1; end
          end else m_quiet++;
          if (abort) begin
            m_stop = 1'b1;
            m_status = (completed && m_fdone == m_req) ? 0 : 2;
            m_phase = PH_GAP; m_gap_left = GAP;
          end else if (completed) begin
            m_phase = PH_GAP; m_gap_left = GAP;
          end else if (m_quiet >= TMO) begin
            m_status = 1; m_stop = 1'b1; m_phase = PH_GAP; m_gap_left = GAP;
          end
        end
        PH_GAP: begin
          if (abort) begin
            m_status = 2; m_stop = 1'b1; m_gap_left = GAP;
          end else begin
            m_gap_left--;
            if (m_gap_left == 0) begin
              if (m_fdone < m_req && !m_stop) begin m_phase = PH_RUN; m_quiet = 0; end
              else m_phase = PH_DONE;
            end
          end
        end
        default: m_phase = PH_IDLE;  // DONE lasts one cycle
      endcase
      if (m_phase == PH_DONE) exp_q.push_back(2'(m_status));
      m_ready_ok = 1'b1;
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("cmd_ready",     cmd_ready,     (m_phase == PH_IDLE) && m_ready_ok);
      check("busy",          busy,          m_phase != PH_IDLE);
      check("proc_start",    proc_start,    m_phase == PH_RUN);
      check("done",          done,          m_phase == PH_DONE);
      check("proc_mode",     proc_mode,     m_mode);
      check("status",        status,        m_status);
      check("frames_done",   frames_done,   m_fdone);
      check("pix_cnt",       pix_cnt,       m_pix);
      check("proc_ready_in", proc_ready_in, sink_ready);
      if (done) begin
        if (exp_q.size() == 0) check("done_unexpected", 1, 0);
        else                   check("done_status", status, exp_q.pop_front());
      end
    end
  end

  // Activity counters for the directed literal expectations
  int start_hi = 0, busy_nostart = 0, beats_seen = 0, done_seen = 0, mode01_hi = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (proc_start) start_hi++;
      if (busy && !proc_start) busy_nostart++;
      if (proc_start && proc_valid_out && sink_ready) beats_seen++;
      if (proc_start && proc_mode == 2'b01) mode01_hi++;
      if (done) done_seen++;
    end
  end

  int b_start, b_busy_ns, b_beats, b_done, b_mode01;
  task automatic snap();
    b_start = start_hi; b_busy_ns = busy_nostart; b_beats = beats_seen;
    b_done = done_seen; b_mode01 = mode01_hi;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] m, input logic [7:0] f, output int waited);
    cmd_mode = m; cmd_frames = f; cmd_valid = 1'b1; waited = 0;
    forever begin
      @(posedge clk);
      waited++;
      if (cmd_ready) break;
      if (waited > 500) begin check("cmd_accept_wait", 0, 1); break; end
    end
    #1 cmd_valid = 1'b0;
  endtask

  // Returns at the negedge of the done cycle, plus one more quiet negedge.
  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) check("done_wait", 0, 1);
    @(negedge clk);
  endtask

  task automatic idle_gap();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    bit hit;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_status", status, 0);
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);
    idle_gap();

    // Bypass, one frame, continuous beats
    snap(); valid_pct = 100; ready_sel = 0;
    send_cmd(2'b00, 8'd1, w);
    wait_done(500);
    check("byp_start_hi", start_hi - b_start, 16);
    check("byp_low_busy", busy_nostart - b_busy_ns, 1 + GAP + 1);
    check("byp_done_cnt", done_seen - b_done, 1);
    check("byp_status", status, 2'b00);
    check("byp_frames", frames_done, 1);
    idle_gap();

    // Invert, three frames, sink_ready toggling
    snap(); ready_sel = 1;
    send_cmd(2'b01, 8'd3, w);
    wait_done(1000);
    check("inv_beats", beats_seen - b_beats, 48);
    check("inv_low_busy", busy_nostart - b_busy_ns, 1 + 3 * GAP + 1);
    check("inv_mode_hold", (start_hi - b_start) - (mode01_hi - b_mode01), 0);
    check("inv_frames", frames_done, 3);
    check("inv_status", status, 2'b00);
    idle_gap();

    // Reserved mode, no beats: timeout
    snap(); ready_sel = 0; valid_pct = 0;
    send_cmd(2'b11, 8'd2, w);
    wait_done(1000);
    check("to_start_hi", start_hi - b_start, TMO);
    check("to_status", status, 2'b01);
    check("to_frames", frames_done, 0);
    check("to_done_cnt", done_seen - b_done, 1);
    idle_gap();

    // Abort on beat 7 of frame 2 of 4
    valid_pct = 100;
    send_cmd(2'b10, 8'd4, w);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (m_phase == PH_RUN && m_fdone == 1 && m_pix == 6) begin hit = 1'b1; break; end
    end
    check("abort_point_found", hit, 1);
    abort_force = 1'b1;
    @(posedge clk); #1 abort_force = 1'b0;
    wait_done(500);
    check("ab_status", status, 2'b10);
    check("ab_frames", frames_done, 1);
    check("ab_pix", pix_cnt, 7);
    idle_gap();

    // Abort on the final beat of the last frame
    send_cmd(2'b00, 8'd1, w);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (m_phase == PH_RUN && m_pix == PPF - 1) begin hit = 1'b1; break; end
    end
    check("final_point_found", hit, 1);
    abort_force = 1'b1;
    @(posedge clk); #1 abort_force = 1'b0;
    wait_done(500);
    check("abfin_status", status, 2'b00);
    check("abfin_frames", frames_done, 1);
    idle_gap();

    // Zero frames, then a command held valid while not ready
    snap();
    send_cmd(2'b10, 8'd0, w);
    fork
      send_cmd(2'b01, 8'd1, w);
      begin
        @(negedge clk);
        check("zero_arm_nodone", done, 0);
        @(negedge clk);
        check("zero_done_t2", done, 1);
      end
    join
    check("held_cmd_edges", w, 3);
    check("zero_no_start", start_hi - b_start, 0);
    wait_done(500);
    check("held_cmd_frames", frames_done, 1);
    idle_gap();

    // Reset in the middle of RUN
    snap();
    send_cmd(2'b00, 8'd3, w);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (m_phase == PH_RUN && m_pix == 5) begin hit = 1'b1; break; end
    end
    check("rst_point_found", hit, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_start_async", proc_start, 0);
    check("rst_busy_async", busy, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("rst_ready_pre_edge", cmd_ready, 0);
    check("rst_frames_zero", frames_done, 0);
    check("rst_pix_zero", pix_cnt, 0);
    @(negedge clk);
    check("rst_ready_post_edge", cmd_ready, 1);
    check("rst_no_done", done_seen - b_done, 0);
    idle_gap();

    // Randomized commands
    for (int i = 0; i < 12; i++) begin
      logic [1:0] rm;
      logic [7:0] rf;
      rm = 2'($urandom_range(3));
      rf = 8'($urandom_range(3));
      valid_pct    = (rm == 2'b11) ? 0 : $urandom_range(100, 50);
      ready_sel    = $urandom_range(2);
      abort_permil = ($urandom_range(1) == 1) ? 5 : 0;
      send_cmd(rm, rf, w);
      wait_done(3000);
      abort_permil = 0;
      idle_gap();
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete by %0t", $time);
    $fatal(1);
  end

endmodule
